// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_to_bin_seq_pkg: shared constants, state encodings and sizing helper for the BCD-to-binary converter.
package bcd_to_bin_seq_pkg;
    localparam int DIGIT_W = 4;
    localparam int DIGIT_MAX = 9;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    // Smallest binary width able to hold 10^digits-1.
    function automatic int min_bin_w(input int digits);
        longint p;
        int w;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        w = 0;
        while ((longint'(1) << w) < p) w++;
        return w;
    endfunction
endpackage

// File: rtl/bcd_to_bin_seq_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble correction, subtracts 3 from a digit field that reached 8 or more.
module bcd_digit_adjust
    import bcd_to_bin_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] fixed
);
    assign fixed = digit >= DIGIT_W'(8) ? digit - DIGIT_W'(3) : digit;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter, one reverse double-dabble step per clock.
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W = 7
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      err
);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (BIN_W < min_bin_w(DIGITS)) begin : g_width_check
        $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
    end

    logic [1:0]       state;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  shifted;
    logic [SR_W-1:0]  sr_next;
    logic [CNT_W-1:0] cnt;
    logic             bad;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign shifted = sr >> 1;
    assign sr_next[BIN_W-1:0] = shifted[BIN_W-1:0];

    // Every digit field is corrected in parallel after the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit(shifted[BIN_W+d*DIGIT_W +: DIGIT_W]),
            .fixed(sr_next[BIN_W+d*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (bcd_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(DIGIT_MAX));
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
            sr <= '0;
            cnt <= '0;
            bin_out <= '0;
            err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (bad) begin
                        bin_out <= '0;
                        err <= 1'b1;
                        state <= DONE;
                    end else begin
                        sr <= {bcd_in, {BIN_W{1'b0}}};
                        cnt <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sr <= sr_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bin_out <= sr_next[BIN_W-1:0];
                        err <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: randomized and directed checks of bcd_to_bin_seq (2 and 3 digits) against an arithmetic model.
module tb_bcd_to_bin_seq;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, err;
    logic [7:0] bcd_in = '0;
    logic [6:0] bin_out;
    logic in_valid3 = 1'b0, out_ready3 = 1'b0, in_ready3, out_valid3, err3;
    logic [11:0] bcd_in3 = '0;
    logic [9:0] bin_out3;
    int total = 0;
    int bad = 0;

    always #5 Clock = ~Clock;

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut (
        .Clock(Clock), .Resetn(Resetn), .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
        .out_valid(out_valid), .out_ready(out_ready), .bin_out(bin_out), .err(err)
    );

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
        .Clock(Clock), .Resetn(Resetn), .in_valid(in_valid3), .in_ready(in_ready3), .bcd_in(bcd_in3),
        .out_valid(out_valid3), .out_ready(out_ready3), .bin_out(bin_out3), .err(err3)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic send2(input logic [7:0] w, input bit pre, input int hold);
        int n, exp_bin, exp_lat;
        bit exp_err;
        exp_err = (w[7:4] > 9) || (w[3:0] > 9);
        exp_bin = exp_err ? 0 : int'(w[7:4]) * 10 + int'(w[3:0]);
        exp_lat = exp_err ? 0 : 7;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_wait w=%h in_ready=%b need 1", w, in_ready); end
        in_valid = 1'b1; bcd_in = w; out_ready = pre;
        step();
        in_valid = 1'b0; bcd_in = 8'($urandom);
        n = 0;
        while (!out_valid && n < 50) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL busy_ready w=%h in_ready=%b need 0", w, in_ready); end
            step(); n++;
        end
        total++;
        if (n != exp_lat) begin bad++; $display("FAIL latency w=%h got=%0d need=%0d", w, n, exp_lat); end
        total++;
        if (bin_out !== 7'(exp_bin)) begin bad++; $display("FAIL bin w=%h got=%0d need=%0d", w, bin_out, exp_bin); end
        total++;
        if (err !== exp_err) begin bad++; $display("FAIL err w=%h got=%b need=%b", w, err, exp_err); end
        if (!exp_err) begin
            total++;
            if (dut.sr[13:7] !== 7'd0) begin bad++; $display("FAIL bcd_zero w=%h got=%h need 0", w, dut.sr[13:7]); end
        end
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom); bcd_in = 8'($urandom);
            step();
            total++;
            if (out_valid !== 1'b1 || bin_out !== 7'(exp_bin) || err !== exp_err || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold w=%h ov=%b bin=%0d err=%b rdy=%b need 1/%0d/%b/0", w, out_valid, bin_out, err, in_ready, exp_bin, exp_err);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL release w=%h rdy=%b ov=%b need 1/0", w, in_ready, out_valid);
        end
    endtask

    task automatic send3(input logic [11:0] w);
        int n, exp_bin, exp_lat;
        bit exp_err;
        exp_err = (w[11:8] > 9) || (w[7:4] > 9) || (w[3:0] > 9);
        exp_bin = exp_err ? 0 : int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
        exp_lat = exp_err ? 0 : 10;
        in_valid3 = 1'b1; bcd_in3 = w;
        step();
        in_valid3 = 1'b0;
        n = 0;
        while (!out_valid3 && n < 50) begin step(); n++; end
        total++;
        if (n != exp_lat || bin_out3 !== 10'(exp_bin) || err3 !== exp_err) begin
            bad++; $display("FAIL conv3 w=%h lat=%0d bin=%0d err=%b need %0d/%0d/%b", w, n, bin_out3, err3, exp_lat, exp_bin, exp_err);
        end
        if (!exp_err) begin
            total++;
            if (dut3.sr[21:10] !== 12'd0) begin bad++; $display("FAIL bcd_zero3 w=%h got=%h need 0", w, dut3.sr[21:10]); end
        end
        out_ready3 = 1'b1;
        step();
        out_ready3 = 1'b0;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        step(); step();
        Resetn = 1'b1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || bin_out !== 7'd0 || err !== 1'b0 || in_ready3 !== 1'b1) begin
            bad++; $display("FAIL reset rdy=%b ov=%b bin=%0d err=%b rdy3=%b need 1/0/0/0/1", in_ready, out_valid, bin_out, err, in_ready3);
        end
    endtask

    task automatic test_basic();
        send2(8'h15, 1'b1, 0);
        send2(8'h00, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        send2(8'h99, 1'b1, 0);
        send2(8'h00, 1'b1, 0);
    endtask

    task automatic test_err();
        send2(8'h1A, 1'b0, 0);
        send2(8'h42, 1'b0, 0);
        send2(8'hF3, 1'b1, 1);
    endtask

    task automatic test_hold();
        send2(8'h37, 1'b0, 5);
    endtask

    task automatic test_midreset();
        in_valid = 1'b1; bcd_in = 8'h64;
        step();
        in_valid = 1'b0;
        step(); step();
        Resetn = 1'b0;
        step();
        Resetn = 1'b1;
        total++;
        if (out_valid !== 1'b0 || bin_out !== 7'd0 || in_ready !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL midreset ov=%b bin=%0d rdy=%b err=%b need 0/0/1/0", out_valid, bin_out, in_ready, err);
        end
        send2(8'h64, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [7:0] w;
        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < 2; d++)
                w[d*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            send2(w, 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_three_digits();
        logic [11:0] w;
        send3(12'h255);
        send3(12'h999);
        send3(12'h000);
        send3(12'h9B1);
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 3; d++) w[d*4 +: 4] = 4'($urandom_range(0, 9));
            send3(w);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_err();
        test_hold();
        test_midreset();
        test_random();
        test_three_digits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
